instruction_fetch_hc: RTL and testbench

Fetch controller that consumes the Program Counter value, issues one instruction-memory read per PC address, and drives the PC's `inc` strobe when a request is accepted. It holds the returned instruction in an output register until the decode stage accepts it. A redirect (branch/jump) flush cancels in-flight work so that the next fetch uses the newly loaded PC. It sits between the Program Counter, the instruction memory port, and the decode stage.

---
 rtl/instruction_fetch_hc_if.sv | 31 +++
 rtl/instruction_fetch_hc.sv | 84 ++++++++
 tb/tb_instruction_fetch_hc.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_hc_if.sv
// Fetch-stage bundle: PC hookup, instruction-memory port and decode handoff.
interface instruction_fetch_hc_if #(
    parameter int unsigned ADDR_SIZE  = 16,
    parameter int unsigned INSTR_SIZE = 16
);
    logic                  fetch_en;
    logic                  flush;
    logic [ADDR_SIZE-1:0]  pc_value;
    logic                  pc_inc;
    logic                  mem_req;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [INSTR_SIZE-1:0] mem_rdata;
    logic                  instr_valid;
    logic [INSTR_SIZE-1:0] instr_data;
    logic [ADDR_SIZE-1:0]  instr_addr;
    logic                  instr_ready;

    // Fetch controller side
    modport master (
        input  fetch_en, flush, pc_value, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        output pc_inc, mem_req, mem_addr, instr_valid, instr_data, instr_addr
    );

    // Surrounding pipeline / memory side
    modport slave (
        output fetch_en, flush, pc_value, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        input  pc_inc, mem_req, mem_addr, instr_valid, instr_data, instr_addr
    );
endinterface

// File: rtl/instruction_fetch_hc.sv
// Fetch controller: one outstanding read per PC value, holds the result for decode,
// and discards in-flight work on a redirect flush.
module instruction_fetch_hc #(
    parameter int unsigned ADDR_SIZE  = 16,
    parameter int unsigned INSTR_SIZE = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    instruction_fetch_hc_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state;
    logic                  drop;
    logic [ADDR_SIZE-1:0]  pend_addr;
    logic                  instr_valid_reg;
    logic [INSTR_SIZE-1:0] instr_data_reg;
    logic [ADDR_SIZE-1:0]  instr_addr_reg;
    logic                  grant_taken;

    // A request is only live in REQ without a flush; a grant counts only with fetching enabled
    assign grant_taken  = (state == REQ) && !bus.flush && bus.fetch_en && bus.mem_gnt;
    assign bus.mem_req  = (state == REQ) && !bus.flush;
    assign bus.pc_inc   = grant_taken;
    assign bus.mem_addr = bus.pc_value;

    assign bus.instr_valid = instr_valid_reg;
    assign bus.instr_data  = instr_data_reg;
    assign bus.instr_addr  = instr_addr_reg;

    // Fetch FSM with registered instruction output and stale-response drop flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            drop            <= 1'b0;
            pend_addr       <= '0;
            instr_valid_reg <= 1'b0;
            instr_data_reg  <= '0;
            instr_addr_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fetch_en) state <= REQ;
                end
                REQ: begin
                    if (grant_taken) begin
                        pend_addr <= bus.pc_value;
                        state     <= WAIT;
                    end else if (!bus.flush && !bus.fetch_en) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (drop || bus.flush) begin
                            drop  <= 1'b0;
                            state <= bus.fetch_en ? REQ : IDLE;
                        end else begin
                            instr_data_reg  <= bus.mem_rdata;
                            instr_addr_reg  <= pend_addr;
                            instr_valid_reg <= 1'b1;
                            state           <= HOLD;
                        end
                    end else if (bus.flush) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    // Flush wins over ready: the held instruction is simply discarded
                    if (bus.flush || bus.instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        state           <= bus.fetch_en ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_hc.sv
// Directed bench for instruction_fetch_hc with a small PC model.
module tb_instruction_fetch_hc;
    logic        clock;
    logic        reset_n;
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_load_val;
    int          vectors;
    int          miscompares;

    instruction_fetch_hc_if #(.ADDR_SIZE(16), .INSTR_SIZE(16)) bus ();

    instruction_fetch_hc #(.ADDR_SIZE(16), .INSTR_SIZE(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program Counter model: load has priority over increment
    always_ff @(posedge clock) begin
        if (pc_load)         pc <= pc_load_val;
        else if (bus.pc_inc) pc <= pc + 16'd1;
    end
    assign bus.pc_value = pc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        pc_load        = 1'b1;
        pc_load_val    = 16'h0010;
        bus.fetch_en   = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        bus.instr_ready = 1'b0;
        #1;
        tick();
        pc_load = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_data",  32'(bus.instr_data),  32'h0);
        chk("rst_addr",  32'(bus.instr_addr),  32'h0);
        chk("rst_req",   32'(bus.mem_req),     32'h0);
        chk("rst_inc",   32'(bus.pc_inc),      32'h0);

        // Straight-line fetch
        reset_n = 1'b1;
        bus.fetch_en = 1'b1;
        tick();                         // IDLE -> REQ
        bus.mem_gnt = 1'b1;
        #1;
        chk("sl0_req",  32'(bus.mem_req),  32'h1);
        chk("sl0_addr", 32'(bus.mem_addr), 32'h0010);
        chk("sl0_inc",  32'(bus.pc_inc),   32'h1);
        tick();                         // WAIT
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'hA5A5;
        #1;
        chk("sl0_wait_req", 32'(bus.mem_req), 32'h0);
        chk("sl0_wait_inc", 32'(bus.pc_inc),  32'h0);
        chk("sl0_pc",       32'(pc),          32'h0011);
        tick();                         // HOLD
        bus.mem_rvalid = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("sl0_valid", 32'(bus.instr_valid), 32'h1);
        chk("sl0_data",  32'(bus.instr_data),  32'hA5A5);
        chk("sl0_iaddr", 32'(bus.instr_addr),  32'h0010);
        tick();                         // REQ
        bus.instr_ready = 1'b0;
        bus.mem_gnt = 1'b1;
        #1;
        chk("sl1_valid", 32'(bus.instr_valid), 32'h0);
        chk("sl1_addr",  32'(bus.mem_addr),    32'h0011);
        chk("sl1_inc",   32'(bus.pc_inc),      32'h1);
        tick();                         // WAIT
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        tick();                         // HOLD
        bus.mem_rvalid = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("sl1_data",  32'(bus.instr_data), 32'h5A5A);
        chk("sl1_iaddr", 32'(bus.instr_addr), 32'h0011);
        tick();                         // REQ again, 3 cycles per instruction
        bus.instr_ready = 1'b0;

        // Redirect to 0x0020 while in REQ; flush suppresses the request
        bus.flush = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0020;
        #1;
        chk("fr_req", 32'(bus.mem_req), 32'h0);
        chk("fr_inc", 32'(bus.pc_inc),  32'h0);
        tick();
        bus.flush = 1'b0;
        pc_load = 1'b0;

        // Grant stall: 4 cycles without grant, grant on the 5th
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("gs_req",  32'(bus.mem_req),  32'h1);
            chk("gs_addr", 32'(bus.mem_addr), 32'h0020);
            chk("gs_inc",  32'(bus.pc_inc),   32'h0);
            tick();
        end
        bus.mem_gnt = 1'b1;
        #1;
        chk("gs_req5", 32'(bus.mem_req), 32'h1);
        chk("gs_inc5", 32'(bus.pc_inc),  32'h1);
        tick();                         // WAIT
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h2222;
        tick();                         // HOLD
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 16'hFFFF;
        // Ready stall: held 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rs_valid", 32'(bus.instr_valid), 32'h1);
            chk("rs_data",  32'(bus.instr_data),  32'h2222);
            chk("rs_iaddr", 32'(bus.instr_addr),  32'h0020);
            chk("rs_req",   32'(bus.mem_req),     32'h0);
            tick();
        end
        chk("rs_pc_once", 32'(pc), 32'h0021);
        bus.instr_ready = 1'b1;
        tick();                         // REQ
        bus.instr_ready = 1'b0;
        #1;
        chk("rs_valid_clr", 32'(bus.instr_valid), 32'h0);

        // Flush in WAIT: grant at 0x0030, redirect to 0x0100, stale 0x1111 dropped
        bus.flush = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0030;
        tick();
        bus.flush = 1'b0;
        pc_load = 1'b0;
        bus.mem_gnt = 1'b1;
        #1;
        chk("fw_addr", 32'(bus.mem_addr), 32'h0030);
        chk("fw_inc",  32'(bus.pc_inc),   32'h1);
        tick();                         // WAIT
        bus.mem_gnt = 1'b0;
        bus.flush = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0100;
        #1;
        chk("fw_inc_flush", 32'(bus.pc_inc), 32'h0);
        tick();                         // WAIT with drop
        bus.flush = 1'b0;
        pc_load = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h1111;
        tick();                         // REQ
        bus.mem_rvalid = 1'b0;
        #1;
        chk("fw_valid", 32'(bus.instr_valid), 32'h0);
        chk("fw_data",  32'(bus.instr_data),  32'h2222);
        chk("fw_req",   32'(bus.mem_req),     32'h1);
        chk("fw_naddr", 32'(bus.mem_addr),    32'h0100);
        bus.mem_gnt = 1'b1;
        tick();                         // WAIT
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h0BEE;
        tick();                         // HOLD
        bus.mem_rvalid = 1'b0;
        #1;
        chk("fw2_data",  32'(bus.instr_data), 32'h0BEE);
        chk("fw2_iaddr", 32'(bus.instr_addr), 32'h0100);

        // Flush together with ready in HOLD: no transfer, redirect to 0x0200
        bus.flush = 1'b1;
        bus.instr_ready = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0200;
        tick();
        bus.flush = 1'b0;
        bus.instr_ready = 1'b0;
        pc_load = 1'b0;
        #1;
        chk("fh_valid", 32'(bus.instr_valid), 32'h0);
        chk("fh_req",   32'(bus.mem_req),     32'h1);
        chk("fh_addr",  32'(bus.mem_addr),    32'h0200);

        // Flush coincident with grant: request suppressed, stays in REQ
        bus.flush = 1'b1;
        bus.mem_gnt = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0300;
        #1;
        chk("fg_req", 32'(bus.mem_req), 32'h0);
        chk("fg_inc", 32'(bus.pc_inc),  32'h0);
        tick();
        bus.flush = 1'b0;
        bus.mem_gnt = 1'b0;
        pc_load = 1'b0;
        #1;
        chk("fg_stay_req", 32'(bus.mem_req),  32'h1);
        chk("fg_addr",     32'(bus.mem_addr), 32'h0300);

        // Asynchronous reset in WAIT
        bus.mem_gnt = 1'b1;
        tick();                         // WAIT, PC now 0x0301
        bus.mem_gnt = 1'b0;
        #1;
        chk("ar_pre_data", 32'(bus.instr_data), 32'h0BEE);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.instr_valid), 32'h0);
        chk("ar_data",  32'(bus.instr_data),  32'h0);
        chk("ar_addr",  32'(bus.instr_addr),  32'h0);
        chk("ar_req",   32'(bus.mem_req),     32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("ar_idle_req", 32'(bus.mem_req), 32'h0);
        tick();                         // IDLE -> REQ
        #1;
        chk("ar_req_rise", 32'(bus.mem_req),  32'h1);
        chk("ar_req_addr", 32'(bus.mem_addr), 32'h0301);

        // fetch_en=0 in HOLD: instruction still transfers, then IDLE
        bus.mem_gnt = 1'b1;
        tick();                         // WAIT
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();                         // HOLD
        bus.mem_rvalid = 1'b0;
        bus.fetch_en = 1'b0;
        tick();                         // still HOLD
        #1;
        chk("fe_valid", 32'(bus.instr_valid), 32'h1);
        chk("fe_data",  32'(bus.instr_data),  32'h7777);
        chk("fe_iaddr", 32'(bus.instr_addr),  32'h0301);
        bus.instr_ready = 1'b1;
        tick();                         // IDLE
        bus.instr_ready = 1'b0;
        #1;
        chk("fe_valid_clr", 32'(bus.instr_valid), 32'h0);
        chk("fe_idle_req",  32'(bus.mem_req),     32'h0);
        // Stray rvalid in IDLE is ignored
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("idle_rv_valid", 32'(bus.instr_valid), 32'h0);
        chk("idle_rv_data",  32'(bus.instr_data),  32'h7777);
        chk("idle_req",      32'(bus.mem_req),     32'h0);
        bus.fetch_en = 1'b1;
        tick();                         // REQ
        #1;
        chk("re_req",  32'(bus.mem_req),  32'h1);
        chk("re_addr", 32'(bus.mem_addr), 32'h0302);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
